// File: rtl/rice_core_operand_fetch.sv
// Operand fetch / issue: reads sources (with execute-result bypass), tracks pending rd in a scoreboard.
// Latency: one cycle from accept to operands on o_ex_*; one instruction per cycle when hazard-free.
// Backpressure: output register holds while o_ex_valid && !i_ex_ready; RAW/WAW hazards drop o_id_ready.
module rice_core_operand_fetch #(
   parameter int XLEN = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_flush,
   input  logic                 i_id_valid,
   output logic                 o_id_ready,
   input  logic [XLEN-1:0]      i_id_pc,
   input  logic [4:0]           i_id_rs1,
   input  logic [4:0]           i_id_rs2,
   input  logic [4:0]           i_id_rd,
   input  logic                 i_id_use_rs1,
   input  logic                 i_id_use_rs2,
   input  logic                 i_id_use_rd,
   input  logic [32*XLEN-1:0]   i_register_file,
   input  logic                 i_ex_result_valid,
   input  logic [4:0]           i_ex_result_rd,
   input  logic [XLEN-1:0]      i_ex_result_rd_value,
   input  logic                 i_ex_result_error,
   output logic                 o_ex_valid,
   input  logic                 i_ex_ready,
   output logic [XLEN-1:0]      o_ex_pc,
   output logic [XLEN-1:0]      o_ex_rs1_value,
   output logic [XLEN-1:0]      o_ex_rs2_value,
   output logic [4:0]           o_ex_rd,
   output logic                 o_ex_use_rd
);

   logic [31:0]     r_pending;
   logic            r_ex_valid;
   logic [XLEN-1:0] r_ex_pc;
   logic [XLEN-1:0] r_ex_rs1_value;
   logic [XLEN-1:0] r_ex_rs2_value;
   logic [4:0]      r_ex_rd;
   logic            r_ex_use_rd;

   logic            w_wr_en;
   logic [31:0]     w_clr_vec;
   logic [31:0]     w_set_vec;
   logic [31:0]     w_pend_eff;
   logic            w_raw1;
   logic            w_raw2;
   logic            w_waw;
   logic            w_hazard;
   logic            w_free;
   logic            w_accept;
   logic [XLEN-1:0] w_rs1_value;
   logic [XLEN-1:0] w_rs2_value;

   // Retiring result: which bit clears, and whether the value is architecturally written
   always_comb begin
      w_wr_en   = i_ex_result_valid && (i_ex_result_rd != 5'd0) && !i_ex_result_error;
      w_clr_vec = '0;
      if (i_ex_result_valid) begin
         w_clr_vec[i_ex_result_rd] = 1'b1;
      end
      // An error result still releases its rd; the stale file value flows on and a flush follows
      w_pend_eff = r_pending & ~w_clr_vec;
   end

   // Hazard detection against the scoreboard as it will look after this cycle's clear
   always_comb begin
      w_raw1   = i_id_use_rs1 && (i_id_rs1 != 5'd0) && w_pend_eff[i_id_rs1];
      w_raw2   = i_id_use_rs2 && (i_id_rs2 != 5'd0) && w_pend_eff[i_id_rs2];
      w_waw    = i_id_use_rd  && (i_id_rd  != 5'd0) && w_pend_eff[i_id_rd];
      w_hazard = w_raw1 || w_raw2 || w_waw;
      w_free   = !r_ex_valid || i_ex_ready;
      w_accept = i_id_valid && w_free && !w_hazard && !i_flush;
   end

   assign o_id_ready = w_free && !w_hazard && !i_flush;

   // Source 1 select: x0/unused -> 0, same-cycle writeback bypass, else register file
   always_comb begin
      w_rs1_value = '0;
      if (i_id_use_rs1 && (i_id_rs1 != 5'd0)) begin
         if (w_wr_en && (i_ex_result_rd == i_id_rs1)) w_rs1_value = i_ex_result_rd_value;
         else                                         w_rs1_value = i_register_file[i_id_rs1*XLEN +: XLEN];
      end
   end

   // Source 2 select: same rules as source 1
   always_comb begin
      w_rs2_value = '0;
      if (i_id_use_rs2 && (i_id_rs2 != 5'd0)) begin
         if (w_wr_en && (i_ex_result_rd == i_id_rs2)) w_rs2_value = i_ex_result_rd_value;
         else                                         w_rs2_value = i_register_file[i_id_rs2*XLEN +: XLEN];
      end
   end

   // Destination claimed by an accepted writer; applied after the clear so set wins
   always_comb begin
      w_set_vec = '0;
      if (w_accept && i_id_use_rd && (i_id_rd != 5'd0)) begin
         w_set_vec[i_id_rd] = 1'b1;
      end
   end

   // Scoreboard update; flush wipes everything, bit 0 is kept clear
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     r_pending <= '0;
      else if (i_flush) r_pending <= '0;
      else              r_pending <= (w_pend_eff | w_set_vec) & 32'hFFFF_FFFE;
   end

   // Output pipeline register: load on accept, drain when free, hold under backpressure
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ex_valid     <= 1'b0;
         r_ex_pc        <= '0;
         r_ex_rs1_value <= '0;
         r_ex_rs2_value <= '0;
         r_ex_rd        <= '0;
         r_ex_use_rd    <= 1'b0;
      end else if (i_flush) begin
         r_ex_valid     <= 1'b0;
      end else if (w_accept) begin
         r_ex_valid     <= 1'b1;
         r_ex_pc        <= i_id_pc;
         r_ex_rs1_value <= w_rs1_value;
         r_ex_rs2_value <= w_rs2_value;
         r_ex_rd        <= i_id_rd;
         r_ex_use_rd    <= i_id_use_rd;
      end else if (w_free) begin
         r_ex_valid     <= 1'b0;
      end
   end

   assign o_ex_valid     = r_ex_valid;
   assign o_ex_pc        = r_ex_pc;
   assign o_ex_rs1_value = r_ex_rs1_value;
   assign o_ex_rs2_value = r_ex_rs2_value;
   assign o_ex_rd        = r_ex_rd;
   assign o_ex_use_rd    = r_ex_use_rd;

endmodule

// File: doc/rice_core_operand_fetch.md
# rice_core_operand_fetch

Operand-fetch/issue stage of the rice core, placed between instruction decode and execute. Reads source operands from the architectural register file and bypasses the execute result being written back in the same cycle. Tracks in-flight destination registers in a 32-entry scoreboard and stalls on RAW/WAW hazards. Presents operands to execute through a single valid/ready pipeline register.

## Interface
- XLEN, 32, data width (32 or 64)
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  discard the held instruction and clear the scoreboard
- i_id_valid  in  1  decoded instruction valid
- o_id_ready  out  1  stage accepts the instruction this cycle
- i_id_pc  in  XLEN  instruction PC
- i_id_rs1, i_id_rs2, i_id_rd  in  5 each  register indices
- i_id_use_rs1, i_id_use_rs2, i_id_use_rd  in  1 each  operand/destination used
- i_register_file  in  32*XLEN  register file read view; entry i at bits [i*XLEN +: XLEN], entry 0 reads 0
- i_ex_result_valid  in  1  execute result retiring this cycle
- i_ex_result_rd  in  5  result destination
- i_ex_result_rd_value  in  XLEN  result value
- i_ex_result_error  in  1  result carries an exception; not written
- o_ex_valid  out  1  held instruction valid
- i_ex_ready  in  1  execute accepts
- o_ex_pc  out  XLEN
- o_ex_rs1_value, o_ex_rs2_value  out  XLEN each
- o_ex_rd  out  5; o_ex_use_rd  out  1

## Operation
- Writable result: i_ex_result_valid && rd != 0 && !error. The register file commits it at the same clock edge.
- Operand select, per source: index 0 or use bit clear gives 0. A writable result with rd == rs gives i_ex_result_rd_value. Otherwise the value comes from i_register_file.
- Scoreboard: 32 pending bits; bit 0 is never set.
- Clear: the bit for i_ex_result_rd clears on any i_ex_result_valid, including error results.
- Set: the bit for i_id_rd sets when an instruction with use_rd and rd != 0 is accepted.
- Set and clear of the same bit in the same cycle: set wins.
- RAW hazard: a used rs is pending and is not cleared this cycle by a valid result with matching rd. If a matching result has error=1, the bit clears and the stale register file value is passed on; a flush is expected to follow.
- WAW hazard: use_rd, rd != 0, and rd pending and not cleared this cycle.
- Free: !o_ex_valid || i_ex_ready.
- o_id_ready = free && !hazard && !i_flush. It is combinational from i_id_*, i_ex_result_*, i_ex_ready and state.
- Accept (i_id_valid && o_id_ready): load the output register with pc, operand values, rd and use_rd; set o_ex_valid.
- Free but no accept: o_ex_valid clears.
- Not free: the output register holds unchanged (stable while o_ex_valid && !i_ex_ready).
- i_flush: o_ex_valid clears, all scoreboard bits clear, no accept. Flush overrides every other event that cycle.

## Timing
- Reset (async assert, sync release): o_ex_valid=0, scoreboard=0, o_ex_pc/rs1/rs2/rd=0, o_ex_use_rd=0. o_id_ready follows its equation, so it is 1 after reset unless flushed.
- Latency: accept at edge N makes operands visible on o_ex_* after edge N.
- Throughput: one instruction per cycle with no hazards and i_ex_ready=1.
- Dependent back-to-back instruction: stalls until execute retires the producer. When i_ex_result_valid for the producer's rd is high, the consumer is accepted in that same cycle with the bypassed value.
- No combinational path from i_ex_ready to o_ex_*.

## Test plan
- Reset then stream of independent ops (rs1=1, rs2=2 holding 0x11/0x22): one accept per cycle, o_ex_rs1_value=0x11, o_ex_rs2_value=0x22, latency 1.
- Issue rd=5, then rs1=5 consumer: o_id_ready=0 until the cycle with i_ex_result_valid, rd=5, value 0xDEAD. The consumer is accepted that cycle with o_ex_rs1_value=0xDEAD. x5 in i_register_file is still old that cycle.
- rd=0 producer (use_rd=1), then rs1=0 consumer: no stall, operand 0, scoreboard stays 0.
- i_ex_ready=0 for 3 cycles with o_ex_valid=1: o_ex_* stable, o_id_ready=0. Release: the held instruction transfers and the next one is accepted in the same cycle.
- WAW: rd=7 pending, new instruction with rd=7 stalls. It is accepted in the cycle rd=7 retires, and bit 7 remains set afterwards.
- i_flush with o_ex_valid=1 and bits 3,7 pending: next cycle o_ex_valid=0, scoreboard=0, a rs1=3 instruction is accepted immediately. Assert i_rst_n low mid-stall: outputs go to reset values asynchronously.
